// File: rtl/qspi_word_packer_pkg.sv
// Shared types and constants for the quad-SPI word packer.
package qspi_pkg;

  localparam int unsigned NIB_PER_WORD = 8;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned NIB_W        = 4;
  localparam int unsigned NIB_CNT_W    = 3;
  localparam int unsigned SKIP_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    PACK = 2'd2
  } state_t;

  // Pin bundle carried through the synchronizer, io[3] = IO3
  typedef struct packed {
    logic             cs;
    logic             sclk;
    logic [NIB_W-1:0] io;
  } qspi_pins_t;

  localparam qspi_pins_t PINS_RST = '{cs: 1'b1, sclk: 1'b0, io: '0};

  function automatic logic [WORD_W-1:0] pack_nib(input logic [WORD_W-1:0] word,
                                                 input logic [NIB_W-1:0]  nib);
    return {word[WORD_W-NIB_W-1:0], nib};
  endfunction

endpackage

// File: rtl/qspi_word_packer_fifo.sv
// Shift-register word FIFO: head entry is always slot 0, so m_data/m_valid come straight from flops.
module qspi_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready_c,
  output logic         full,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             pop;
  logic             push;
  logic             placed;

  // A pop frees the tail slot in the same cycle, so a full FIFO can still accept
  assign pop       = vld_q[0] & m_ready;
  assign s_ready_c = ~vld_q[DEPTH-1] | pop;
  assign push      = s_valid & s_ready_c;

  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    placed = 1'b0;
    if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!placed && !vld_d[i]) begin
          mem_d[i] = s_data;
          vld_d[i] = 1'b1;
          placed   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
    end
  end

  assign m_data  = mem_q[0];
  assign m_valid = vld_q[0];
  assign full    = vld_q[DEPTH-1];

endmodule

// File: rtl/qspi_word_packer.sv
// Quad-SPI snooper: packs 8 nibbles per 32-bit word into a FIFO after skipping DUMMY_NIB nibbles.
// Optional 8-bit saturating drop counter output when QSPI_PACK_OVF_CNT_EN is defined.
module qspi_word_packer
  import qspi_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DUMMY_NIB = 0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              CS,
  input  logic              CLOCK,
  input  logic              IO0,
  input  logic              IO1,
  input  logic              IO2,
  input  logic              IO3,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frag,
  output logic              ovf
`ifdef QSPI_PACK_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  localparam logic [SKIP_CNT_W-1:0] DUMMY_CNT = SKIP_CNT_W'(DUMMY_NIB);
  localparam logic [NIB_CNT_W-1:0]  LAST_NIB  = NIB_CNT_W'(NIB_PER_WORD - 1);

  qspi_pins_t             pins_raw;
  qspi_pins_t             meta_q;
  qspi_pins_t             sync_q;
  logic                   cs_prev_q;
  logic                   sclk_prev_q;
  logic [1:0]             warm_q;
  logic                   armed_q;
  state_t                 state_q, state_d;
  logic [SKIP_CNT_W-1:0]  skip_q, skip_d;
  logic [NIB_CNT_W-1:0]   nib_q, nib_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic                   frag_q, frag_d;
  logic                   ovf_q;
  logic                   wr_valid;
  logic [WORD_W-1:0]      wr_data;
  logic                   fifo_ready_c;
  logic                   fifo_full;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sample_ev;
  logic                   drop;

  assign pins_raw = {CS, CLOCK, IO3, IO2, IO1, IO0};

  assign cs_fall   = cs_prev_q & ~sync_q.cs;
  assign cs_rise   = ~cs_prev_q & sync_q.cs;
  // A clock rise on the same cycle CS rises still counts: CS was low when it was launched
  assign sample_ev = sync_q.sclk & ~sclk_prev_q & ~(sync_q.cs & cs_prev_q);
  assign wr_data   = pack_nib(word_q, sync_q.io);
  assign drop      = wr_valid & fifo_full & ~fifo_ready_c;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      meta_q      <= PINS_RST;
      sync_q      <= PINS_RST;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      skip_q      <= '0;
      nib_q       <= '0;
      word_q      <= '0;
      frag_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      meta_q      <= pins_raw;
      sync_q      <= meta_q;
      cs_prev_q   <= sync_q.cs;
      sclk_prev_q <= sync_q.sclk;
      warm_q      <= {warm_q[0], 1'b1};
      // Only a CS level seen after the synchronizer has flushed may arm the next frame
      armed_q     <= armed_q | (warm_q[1] & sync_q.cs);
      state_q     <= state_d;
      skip_q      <= skip_d;
      nib_q       <= nib_d;
      word_q      <= word_d;
      frag_q      <= frag_d;
      ovf_q       <= ovf_q | drop;
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    nib_d    = nib_q;
    word_d   = word_q;
    frag_d   = 1'b0;
    wr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          skip_d  = '0;
          nib_d   = '0;
          word_d  = '0;
          state_d = (DUMMY_NIB > 0) ? SKIP : PACK;
        end
      end
      SKIP: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sample_ev) begin
          if (skip_q + 8'd1 == DUMMY_CNT) begin
            skip_d  = '0;
            state_d = PACK;
          end else begin
            skip_d = skip_q + 8'd1;
          end
        end
      end
      PACK: begin
        if (sample_ev) begin
          word_d   = wr_data;
          nib_d    = nib_q + 3'd1;
          wr_valid = (nib_q == LAST_NIB);
        end
        if (cs_rise) begin
          state_d = IDLE;
          frag_d  = (nib_d != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  qspi_word_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .s_data    (wr_data),
    .s_valid   (wr_valid),
    .s_ready_c (fifo_ready_c),
    .full      (fifo_full),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  assign frag = frag_q;
  assign ovf  = ovf_q;

`ifdef QSPI_PACK_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ovf_cnt_q <= '0;
    end else if (drop && ovf_cnt_q != 8'hFF) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_qspi_word_packer.sv
// Bench for qspi_word_packer: two instances (DUMMY_NIB 0 and 2) share the pins, checked against a frame-level model.
module tb_qspi_word_packer;

  typedef logic [31:0] word_q_t[$];

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        CS;
  logic        CLOCK;
  logic        IO0, IO1, IO2, IO3;
  logic        m_ready;
  logic [31:0] m_data0, m_data2;
  logic        m_valid0, m_valid2;
  logic        frag0, frag2;
  logic        ovf0, ovf2;
`ifdef QSPI_PACK_OVF_CNT_EN
  logic [7:0]  ovf_cnt0, ovf_cnt2;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [3:0]  frame[$];
  logic [31:0] got0[$];
  logic [31:0] got2[$];
  int          frag0_n = 0;
  int          frag2_n = 0;

  always #5 ACLK = ~ACLK;

  qspi_word_packer #(.DEPTH(4), .DUMMY_NIB(0)) dut0 (
    .ACLK(ACLK), .ARESET(ARESET), .CS(CS), .CLOCK(CLOCK),
    .IO0(IO0), .IO1(IO1), .IO2(IO2), .IO3(IO3),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
    .frag(frag0), .ovf(ovf0)
`ifdef QSPI_PACK_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt0)
`endif
  );

  qspi_word_packer #(.DEPTH(4), .DUMMY_NIB(2)) dut2 (
    .ACLK(ACLK), .ARESET(ARESET), .CS(CS), .CLOCK(CLOCK),
    .IO0(IO0), .IO1(IO1), .IO2(IO2), .IO3(IO3),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
    .frag(frag2), .ovf(ovf2)
`ifdef QSPI_PACK_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt2)
`endif
  );

  // Collect accepted words and frag pulses mid-low-phase, clear of both edges
  always @(negedge ACLK) begin
    #2;
    if (!ARESET) begin
      if (m_valid0 && m_ready) got0.push_back(m_data0);
      if (m_valid2 && m_ready) got2.push_back(m_data2);
      if (frag0) frag0_n++;
      if (frag2) frag2_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Frame-level reference: drop the first dummy nibbles, every 8 left make a word, leftovers mean frag
  task automatic model(input int dummy, input int cap, output word_q_t w, output int frag_exp);
    int unsigned acc;
    int          cnt;
    w   = {};
    acc = 0;
    cnt = 0;
    for (int i = 0; i < frame.size(); i++) begin
      if (i >= dummy) begin
        acc = acc * 16 + 32'(frame[i]);
        cnt++;
        if (cnt == 8) begin
          if (cap == 0 || w.size() < cap) w.push_back(acc);
          acc = 0;
          cnt = 0;
        end
      end
    end
    frag_exp = (cnt != 0) ? 1 : 0;
  endtask

  task automatic compare(input string tag, input word_q_t got, input int frag_n,
                         input int dummy, input int cap);
    word_q_t exp;
    int      ef;
    model(dummy, cap, exp, ef);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), got[i], exp[i]);
    chk({tag, "_frag"}, 32'(frag_n), 32'(ef));
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (5) @(negedge ACLK);
  endtask

  // mode 1: check m_valid latency; mode 2: raise m_ready for the write cycle; mode 3: CS rises with CLOCK
  task automatic send_nib(input logic [3:0] n, input int mode);
    {IO3, IO2, IO1, IO0} = n;
    repeat (2) @(negedge ACLK);
    CLOCK = 1'b1;
    if (mode == 3) CS = 1'b1;
    repeat (2) @(negedge ACLK);
    if (mode == 1) chk("lat_cycle2", 32'(m_valid0), 32'd0);
    if (mode == 2) m_ready = 1'b1;
    if (mode == 1 || mode == 2) begin
      @(negedge ACLK);
      if (mode == 1) chk("lat_cycle3", 32'(m_valid0), 32'd1);
      @(negedge ACLK);
      if (mode == 1) chk("valid_one_cycle", 32'(m_valid0), 32'd0);
    end
    CLOCK = 1'b0;
  endtask

  task automatic run_frame(input int last_mode);
    got0.delete();
    got2.delete();
    frag0_n = 0;
    frag2_n = 0;
    CS = 1'b0;
    repeat (4) @(negedge ACLK);
    for (int i = 0; i < frame.size(); i++)
      send_nib(frame[i], (i == frame.size() - 1) ? last_mode : 0);
    repeat (2) @(negedge ACLK);
    CS = 1'b1;
    repeat (8) @(negedge ACLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid0"}, 32'(m_valid0), 32'd0);
    chk({tag, "_data0"},  m_data0,       32'd0);
    chk({tag, "_frag0"},  32'(frag0),    32'd0);
    chk({tag, "_ovf0"},   32'(ovf0),     32'd0);
    chk({tag, "_valid2"}, 32'(m_valid2), 32'd0);
    chk({tag, "_ovf2"},   32'(ovf2),     32'd0);
  endtask

  initial begin
    word_q_t ref_w;
    int      ref_f;
    ARESET  = 1'b1;
    CS      = 1'b1;
    CLOCK   = 1'b0;
    {IO3, IO2, IO1, IO0} = 4'h0;
    m_ready = 1'b1;
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESET = 1'b0;
    repeat (5) @(negedge ACLK);

    // Nibbles 1..8 make 0x12345678 with exact output latency
    frame = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    run_frame(1);
    compare("seq_d0", got0, frag0_n, 0, 0);
    compare("seq_d2", got2, frag2_n, 2, 0);
    chk("seq_const", (got0.size() > 0) ? got0[0] : 32'hDEAD0000, 32'h12345678);

    // Dummy nibbles F,E are discarded by the DUMMY_NIB=2 instance
    frame = {4'hF, 4'hE, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
    run_frame(0);
    compare("dummy_d0", got0, frag0_n, 0, 0);
    compare("dummy_d2", got2, frag2_n, 2, 0);

    // Short frame: partial word discarded, frag pulse
    frame = {};
    for (int i = 0; i < 5; i++) frame.push_back(4'($urandom_range(0, 15)));
    run_frame(0);
    compare("short_d0", got0, frag0_n, 0, 0);
    compare("short_d2", got2, frag2_n, 2, 0);

    // CS rise on the same cycle as the eighth clock rise still writes the word
    frame = {};
    for (int i = 0; i < 8; i++) frame.push_back(4'($urandom_range(0, 15)));
    run_frame(3);
    compare("coinc_d0", got0, frag0_n, 0, 0);
    compare("coinc_d2", got2, frag2_n, 2, 0);

    // Five words into a depth-4 FIFO with the consumer stalled
    frame = {};
    for (int i = 0; i < 40; i++) frame.push_back(4'($urandom_range(0, 15)));
    m_ready = 1'b0;
    run_frame(0);
    model(0, 0, ref_w, ref_f);
    chk("ovf_set_d0", 32'(ovf0), 32'd1);
    chk("ovf_clear_d2", 32'(ovf2), 32'd0);
`ifdef QSPI_PACK_OVF_CNT_EN
    chk("ovf_cnt_d0", 32'(ovf_cnt0), 32'd1);
    chk("ovf_cnt_d2", 32'(ovf_cnt2), 32'd0);
`endif
    chk("stall_valid", 32'(m_valid0), 32'd1);
    chk("stall_head", m_data0, ref_w[0]);
    repeat (3) @(negedge ACLK);
    chk("stall_stable", m_data0, ref_w[0]);
    m_ready = 1'b1;
    repeat (10) @(negedge ACLK);
    compare("ovf_d0", got0, frag0_n, 0, 4);
    compare("ovf_d2", got2, frag2_n, 2, 4);
    chk("ovf_sticky", 32'(ovf0), 32'd1);

    do_reset();
    chk("ovf_after_reset", 32'(ovf0), 32'd0);

    // Full FIFO popped on the same cycle the fifth word arrives: nothing dropped
    frame = {};
    for (int i = 0; i < 40; i++) frame.push_back(4'($urandom_range(0, 15)));
    m_ready = 1'b0;
    run_frame(2);
    repeat (4) @(negedge ACLK);
    compare("pushpop_d0", got0, frag0_n, 0, 0);
    compare("pushpop_d2", got2, frag2_n, 2, 0);
    chk("pushpop_ovf", 32'(ovf0), 32'd0);

    // Reset mid-frame with CS held low: ignored until a fresh CS fall
    got0.delete();
    got2.delete();
    frag0_n = 0;
    frag2_n = 0;
    CS = 1'b0;
    repeat (4) @(negedge ACLK);
    for (int i = 0; i < 3; i++) send_nib(4'($urandom_range(0, 15)), 0);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    check_reset_outputs("midreset");
    for (int i = 0; i < 8; i++) send_nib(4'($urandom_range(0, 15)), 0);
    repeat (2) @(negedge ACLK);
    CS = 1'b1;
    repeat (8) @(negedge ACLK);
    chk("midreset_words0", 32'(got0.size()), 32'd0);
    chk("midreset_frag0", 32'(frag0_n), 32'd0);
    chk("midreset_words2", 32'(got2.size()), 32'd0);
    frame = {4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'hA, 4'hF, 4'hE};
    run_frame(0);
    compare("cafe_d0", got0, frag0_n, 0, 0);
    compare("cafe_d2", got2, frag2_n, 2, 0);
    chk("cafe_const", (got0.size() > 0) ? got0[0] : 32'hDEAD0000, 32'h0000CAFE);

    // Random frames, including multi-word wrap and CS-with-clock coincidence
    for (int r = 0; r < 6; r++) begin
      frame = {};
      for (int i = 0, n = $urandom_range(1, 26); i < n; i++)
        frame.push_back(4'($urandom_range(0, 15)));
      run_frame(($urandom_range(0, 1) == 1) ? 3 : 0);
      compare($sformatf("rand%0d_d0", r), got0, frag0_n, 0, 0);
      compare($sformatf("rand%0d_d2", r), got2, frag2_n, 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
